// File: rtl/ft_tx_arbiter.sv
// ============================================================================
// ft_tx_arbiter : round-robin framer of 4 FWFT packet sources into FT2232 OUT FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

module ft_tx_arbiter (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [3:0]  req_i,
  input  logic [23:0] len_i,
  input  logic [31:0] data_i,
  output logic [3:0]  data_rd_o,
  output logic [3:0]  grant_o,
  output logic        busy_o,
  output logic        wr_out_fifo_en_o,
  output logic [7:0]  wr_out_fifo_data_o,
  input  logic        wr_out_fifo_full_i,
  input  logic        wr_out_fifo_afull_i
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SYNC    = 3'd1;
  localparam logic [2:0] S_HDR     = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_CSUM    = 3'd4;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  logic [2:0] state_q, state_d;
  logic [1:0] win_q, win_d;
  logic [1:0] last_q, last_d;
  logic [5:0] len_q, len_d;
  logic [5:0] cnt_q, cnt_d;
  logic [7:0] csum_q, csum_d;
  logic [7:0] data_q, data_d;
  logic [3:0] grant_q, grant_d;
  logic       en_q, en_d;
  logic       busy_q, busy_d;

  logic       space;
  logic [1:0] rr_idx;
  logic       rr_found;
  logic [5:0] len_arr [4];
  logic [7:0] data_sel;

  assign space    = ~wr_out_fifo_full_i & ~wr_out_fifo_afull_i;
  assign data_sel = data_i[{win_q, 3'b000} +: 8];

  // Round-robin search begins one past the previous winner.
  always_comb begin
    rr_idx   = 2'd0;
    rr_found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      logic [1:0] cand;
      cand = last_q + 2'(i);
      if (!rr_found && req_i[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      len_arr[k] = len_i[6*k +: 6];
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (rr_found) state_d = S_SYNC;
      S_SYNC:    if (space) state_d = S_HDR;
      S_HDR:     if (space) state_d = S_PAYLOAD;
      S_PAYLOAD: if (space && (cnt_q == len_q)) state_d = S_CSUM;
      S_CSUM:    if (space) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Every write is registered; a cycle without space leaves en low and all context held.
  always_comb begin
    en_d      = 1'b0;
    data_d    = data_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    win_d     = win_q;
    last_d    = last_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    csum_d    = csum_q;
    data_rd_o = 4'b0000;
    case (state_q)
      S_IDLE: begin
        if (rr_found) begin
          win_d   = rr_idx;
          len_d   = len_arr[rr_idx];
          grant_d = 4'b0001 << rr_idx;
          busy_d  = 1'b1;
        end
      end
      S_SYNC: begin
        if (space) begin
          en_d   = 1'b1;
          data_d = SYNC_BYTE;
        end
      end
      S_HDR: begin
        if (space) begin
          en_d   = 1'b1;
          data_d = {win_q, len_q};
          cnt_d  = 6'd0;
          csum_d = 8'h00;
        end
      end
      S_PAYLOAD: begin
        if (space) begin
          data_rd_o = 4'b0001 << win_q;
          en_d      = 1'b1;
          data_d    = data_sel;
          csum_d    = csum_q ^ data_sel;
          cnt_d     = cnt_q + 6'd1;
        end
      end
      S_CSUM: begin
        if (space) begin
          en_d    = 1'b1;
          data_d  = csum_q;
          grant_d = 4'b0000;
          busy_d  = 1'b0;
          last_d  = win_q;
        end
      end
      default: begin
        en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      en_q    <= 1'b0;
      data_q  <= 8'h00;
      grant_q <= 4'b0000;
      busy_q  <= 1'b0;
      win_q   <= 2'd0;
      last_q  <= 2'd3;
      len_q   <= 6'd0;
      cnt_q   <= 6'd0;
      csum_q  <= 8'h00;
    end else begin
      en_q    <= en_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      win_q   <= win_d;
      last_q  <= last_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
    end
  end

  assign grant_o            = grant_q;
  assign busy_o             = busy_q;
  assign wr_out_fifo_en_o   = en_q;
  assign wr_out_fifo_data_o = data_q;

endmodule

`default_nettype wire

// File: tb/tb_ft_tx_arbiter.sv
// ============================================================================
// tb_ft_tx_arbiter : scoreboard bench for ft_tx_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ft_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req = 4'b0;
  logic [23:0] len = 24'b0;
  logic [31:0] data_bus = 32'b0;
  logic        full = 1'b0;
  logic        afull = 1'b0;
  logic [3:0]  data_rd;
  logic [3:0]  grant;
  logic        busy;
  logic        wr_en;
  logic [7:0]  wr_data;

  ft_tx_arbiter dut (
    .clk_i               (clk),
    .reset_n_i           (reset_n),
    .req_i               (req),
    .len_i               (len),
    .data_i              (data_bus),
    .data_rd_o           (data_rd),
    .grant_o             (grant),
    .busy_o              (busy),
    .wr_out_fifo_en_o    (wr_en),
    .wr_out_fifo_data_o  (wr_data),
    .wr_out_fifo_full_i  (full),
    .wr_out_fifo_afull_i (afull)
  );

  always #5 clk = ~clk;

  logic [7:0] src [4][$];
  logic [7:0] exp_q [$];
  int         exp_grant [$];
  int         tests = 0;
  int         fails = 0;
  int         pop_cnt [4] = '{0, 0, 0, 0};
  int         grant_cnt = 0;
  logic       nospace_prev = 1'b0;
  logic [3:0] grant_prev = 4'b0;
  logic [7:0] csum_run = 8'h00;
  logic [7:0] e;
  int         g;

  // FWFT requester model: pop on strobe, present the new head shortly after the edge.
  always begin
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (data_rd[k]) begin
        if (src[k].size() > 0) void'(src[k].pop_front());
        pop_cnt[k]++;
      end
    end
    #2;
    for (int k = 0; k < 4; k++) begin
      data_bus[8*k +: 8] = (src[k].size() > 0) ? src[k][0] : 8'h00;
    end
  end

  // Monitor: compares writes and grants against the scoreboard queues.
  always @(negedge clk) begin
    if (reset_n) begin
      if (wr_en) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_write: got %02h, expected no write", wr_data);
        end else begin
          e = exp_q.pop_front();
          if (wr_data !== e) begin
            fails++;
            $display("FAIL frame_byte: got %02h, expected %02h", wr_data, e);
          end
        end
      end
      if (nospace_prev) begin
        tests++;
        if (wr_en !== 1'b0) begin
          fails++;
          $display("FAIL stall_write: got en=%b, expected 0", wr_en);
        end
      end
      if (full || afull) begin
        tests++;
        if (data_rd !== 4'b0) begin
          fails++;
          $display("FAIL stall_pop: got data_rd=%b, expected 0000", data_rd);
        end
      end
      if (grant != 4'b0 && grant_prev == 4'b0) begin
        grant_cnt++;
        tests++;
        if (exp_grant.size() == 0) begin
          fails++;
          $display("FAIL grant_order: got %b, expected no grant", grant);
        end else begin
          g = exp_grant.pop_front();
          if (grant !== (4'b0001 << g)) begin
            fails++;
            $display("FAIL grant_order: got %b, expected %b", grant, 4'b0001 << g);
          end
        end
      end
    end
    nospace_prev = full | afull;
    grant_prev   = grant;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic frame_begin(input int k, input logic [5:0] l);
    logic [1:0] kk;
    kk = k[1:0];
    exp_q.push_back(8'hA5);
    exp_q.push_back({kk, l});
    exp_grant.push_back(k);
    len[6*k +: 6] = l;
    csum_run = 8'h00;
  endtask

  task automatic frame_byte(input int k, input logic [7:0] b);
    src[k].push_back(b);
    exp_q.push_back(b);
    csum_run = csum_run ^ b;
  endtask

  task automatic frame_end();
    exp_q.push_back(csum_run);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_en", {31'b0, wr_en}, 32'h0);
    chk("rst_data", {24'b0, wr_data}, 32'h0);
    chk("rst_grant", {28'b0, grant}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_data_rd", {28'b0, data_rd}, 32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(1);
  endtask

  task automatic wait_grant();
    int n = 0;
    while (grant == 4'b0 && n < 100) begin
      tick(1);
      n++;
    end
    chk("grant_seen", {31'b0, grant != 4'b0}, 32'h1);
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < budget) begin
      tick(1);
      n++;
    end
    tick(2);
    chk("frame_done_busy", {31'b0, busy}, 32'h0);
    chk("frame_done_drain", exp_q.size(), 32'h0);
  endtask

  task automatic wait_pops(input int k, input int target);
    int n = 0;
    while (pop_cnt[k] < target && n < 200) begin
      tick(1);
      n++;
    end
    chk("pop_wait", pop_cnt[k], target);
  endtask

  initial begin
    int p [4];
    int n;

    // Single requester, len 2: A5,02,11,22,33,00; busy falls with the checksum write.
    do_reset();
    frame_begin(0, 6'd2);
    frame_byte(0, 8'h11);
    frame_byte(0, 8'h22);
    frame_byte(0, 8'h33);
    frame_end();
    p[0] = pop_cnt[0];
    tick(1);
    req = 4'b0001;
    wait_grant();
    n = 0;
    while (busy && n < 100) begin
      tick(1);
      n++;
    end
    req = 4'b0000;
    chk("busy_fall_with_csum", {23'b0, wr_en, wr_data}, {23'b0, 1'b1, 8'h00});
    wait_done(50);
    chk("t1_pops", pop_cnt[0] - p[0], 32'd3);

    // All four requesting, len 0: grants 0,1,2,3,0 from reset.
    do_reset();
    for (int f = 0; f < 5; f++) begin
      frame_begin(f % 4, 6'd0);
      frame_byte(f % 4, 8'h40 + 8'(f % 4));
      frame_end();
    end
    for (int k = 0; k < 4; k++) p[k] = pop_cnt[k];
    n = grant_cnt;
    req = 4'b1111;
    for (int c = 0; c < 200 && grant_cnt < n + 5; c++) tick(1);
    chk("t2_grant_count", grant_cnt - n, 32'd5);
    req = 4'b0000;
    wait_done(50);
    chk("t2_pops0", pop_cnt[0] - p[0], 32'd2);
    chk("t2_pops3", pop_cnt[3] - p[3], 32'd1);

    // afull stall for 3 cycles mid-payload, len 5.
    frame_begin(1, 6'd5);
    frame_byte(1, 8'h01);
    frame_byte(1, 8'h02);
    frame_byte(1, 8'h04);
    frame_byte(1, 8'h08);
    frame_byte(1, 8'h10);
    frame_byte(1, 8'h20);
    frame_end();
    p[1] = pop_cnt[1];
    req = 4'b0010;
    wait_grant();
    req = 4'b0000;
    wait_pops(1, p[1] + 2);
    afull = 1'b1;
    tick(3);
    afull = 1'b0;
    chk("t3_no_pop_in_stall", pop_cnt[1] - p[1], 32'd2);
    wait_done(50);
    chk("t3_pops", pop_cnt[1] - p[1], 32'd6);

    // Request dropped after grant, len 63; a full-flag stall too.
    frame_begin(2, 6'd63);
    for (int i = 0; i < 64; i++) frame_byte(2, 8'(i * 5 + 7));
    frame_end();
    p[2] = pop_cnt[2];
    req = 4'b0100;
    wait_grant();
    req = 4'b0000;
    tick(10);
    full = 1'b1;
    tick(2);
    full = 1'b0;
    wait_done(300);
    chk("t4_pops", pop_cnt[2] - p[2], 32'd64);

    // Reset during payload byte 3 aborts the frame; a fresh frame follows.
    frame_begin(0, 6'd7);
    frame_byte(0, 8'h10);
    frame_byte(0, 8'h11);
    for (int i = 2; i < 8; i++) src[0].push_back(8'h10 + 8'(i));
    p[0] = pop_cnt[0];
    req = 4'b0001;
    wait_grant();
    req = 4'b0000;
    wait_pops(0, p[0] + 3);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5_rst_en", {31'b0, wr_en}, 32'h0);
    chk("t5_rst_grant", {28'b0, grant}, 32'h0);
    chk("t5_rst_busy", {31'b0, busy}, 32'h0);
    src[0].delete();
    tick(2);
    reset_n = 1'b1;
    tick(3);
    chk("t5_abort_drained", exp_q.size(), 32'h0);
    frame_begin(1, 6'd1);
    frame_byte(1, 8'h5A);
    frame_byte(1, 8'hC3);
    frame_end();
    p[1] = pop_cnt[1];
    req = 4'b0010;
    wait_grant();
    req = 4'b0000;
    wait_done(50);
    chk("t5_pops", pop_cnt[1] - p[1], 32'd2);
    chk("grant_queue_drained", exp_grant.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
